conv_mac_pe: RTL and testbench

CONV_MAC_PE -- requirements
Module: conv_mac_pe

---
 rtl/conv_pe_pkg.sv | 15 +
 rtl/conv_pe_mac.sv | 47 ++++
 rtl/conv_mac_pe.sv | 102 ++++++++++
 tb/tb_conv_mac_pe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pe_pkg.sv
// Shared types and sizing helpers for the convolution MAC processing element.
package conv_pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_t;

  // Bits needed to count from 0 up to and including num_taps.
  function automatic int zero_count_width(input int num_taps);
    return $clog2(num_taps + 1);
  endfunction

endpackage

// File: rtl/conv_pe_mac.sv
// Zero-gated multiply-add step of the conv PE; saturating when CONV_PE_SAT_EN is defined,
// two's-complement wrapping otherwise.
module conv_pe_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int VALUE_WIDTH = 2
) (
  input  logic signed [DATA_WIDTH-1:0]  acc,
  input  logic signed [VALUE_WIDTH-1:0] weight,
  input  logic signed [VALUE_WIDTH-1:0] infmap_value,
  output logic signed [DATA_WIDTH-1:0]  acc_next,
  output logic                          tap_zero
);

  logic signed [2*VALUE_WIDTH-1:0] product;
  logic signed [DATA_WIDTH-1:0]    product_ext;

  assign tap_zero    = (infmap_value == '0);
  assign product     = weight * infmap_value;
  assign product_ext = DATA_WIDTH'(product);

`ifdef CONV_PE_SAT_EN
  logic [DATA_WIDTH:0] wide_sum;

  assign wide_sum = {acc[DATA_WIDTH-1], acc} + {product_ext[DATA_WIDTH-1], product_ext};

  // A sign disagreement between the two top bits means the true sum left the signed range.
  always_comb begin
    acc_next = acc;
    if (!tap_zero) begin
      if (wide_sum[DATA_WIDTH] != wide_sum[DATA_WIDTH-1]) begin
        acc_next = wide_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        acc_next = wide_sum[DATA_WIDTH-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_next = acc;
    if (!tap_zero) begin
      acc_next = acc + product_ext;
    end
  end
`endif

endmodule

// File: rtl/conv_mac_pe.sv
// Convolution MAC processing element: loads a partial sum, accumulates NUM_TAPS weight*ifmap taps
// (skipping zero ifmap values), then presents the result. Optional saturation via CONV_PE_SAT_EN.
module conv_mac_pe
  import conv_pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int VALUE_WIDTH = 2,
  parameter int NUM_TAPS    = 9
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic signed [DATA_WIDTH-1:0]              inpsum,
  input  logic                                      tap_valid,
  output logic                                      tap_ready,
  input  logic signed [VALUE_WIDTH-1:0]             weight,
  input  logic signed [VALUE_WIDTH-1:0]             infmap_value,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [DATA_WIDTH-1:0]              outpsum,
  output logic [zero_count_width(NUM_TAPS)-1:0]     zero_count
);

  localparam int CW = zero_count_width(NUM_TAPS);

  pe_state_t                    state_q, state_d;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] acc_next;
  logic [CW-1:0]                tap_cnt;
  logic [CW-1:0]                zero_cnt;
  logic [CW-1:0]                zero_cnt_next;
  logic                         tap_zero;
  logic                         tap_fire;
  logic                         last_tap;

  conv_pe_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_mac (
    .acc          (acc),
    .weight       (weight),
    .infmap_value (infmap_value),
    .acc_next     (acc_next),
    .tap_zero     (tap_zero)
  );

  assign tap_fire      = tap_valid && tap_ready;
  assign last_tap      = (tap_cnt == CW'(NUM_TAPS - 1));
  assign zero_cnt_next = zero_cnt + CW'(tap_zero);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    tap_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        tap_ready = 1'b1;
        if (tap_valid && last_tap) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are captured on the final tap so they are ready in DONE and held until the next final tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc        <= '0;
      tap_cnt    <= '0;
      zero_cnt   <= '0;
      outpsum    <= '0;
      zero_count <= '0;
    end else begin
      state_q <= state_d;
      if (in_valid && in_ready) begin
        acc      <= inpsum;
        tap_cnt  <= '0;
        zero_cnt <= '0;
      end
      if (tap_fire) begin
        acc      <= acc_next;
        tap_cnt  <= tap_cnt + CW'(1);
        zero_cnt <= zero_cnt_next;
        if (last_tap) begin
          outpsum    <= acc_next;
          zero_count <= zero_cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pe.sv
// Self-checking bench for conv_mac_pe (DATA_WIDTH=8, VALUE_WIDTH=2, NUM_TAPS=3) with a result scoreboard.
module tb_conv_mac_pe;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] inpsum;
  logic              tap_valid;
  logic              tap_ready;
  logic signed [1:0] weight;
  logic signed [1:0] infmap_value;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] outpsum;
  logic [1:0]        zero_count;

  conv_mac_pe #(
    .DATA_WIDTH  (8),
    .VALUE_WIDTH (2),
    .NUM_TAPS    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inpsum       (inpsum),
    .tap_valid    (tap_valid),
    .tap_ready    (tap_ready),
    .weight       (weight),
    .infmap_value (infmap_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .outpsum      (outpsum),
    .zero_count   (zero_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [7:0] psum;
    logic [2:0][1:0]   w;
    logic [2:0][1:0]   x;
    logic signed [7:0] exp_out;
    logic [1:0]        exp_zero;
    logic [1:0]        gap;
  } vec_t;

  typedef struct packed {
    logic signed [7:0] out;
    logic [1:0]        zc;
  } exp_t;

  vec_t              vecs [4];
  exp_t              sb [$];
  exp_t              mon_exp;
  int                n_checks = 0;
  int                n_fails  = 0;
  logic signed [7:0] last_out = '0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input int psum, input int w0, input int w1, input int w2,
                                 input int x0, input int x1, input int x2,
                                 input int exp_out, input int exp_zero, input int gap);
    vec_t v;
    v.psum     = 8'(psum);
    v.w[0]     = 2'(w0);
    v.w[1]     = 2'(w1);
    v.w[2]     = 2'(w2);
    v.x[0]     = 2'(x0);
    v.x[1]     = 2'(x1);
    v.x[2]     = 2'(x2);
    v.exp_out  = 8'(exp_out);
    v.exp_zero = 2'(exp_zero);
    v.gap      = 2'(gap);
    return v;
  endfunction

  // Reference accumulation, written as plain integer arithmetic then folded into 8 bits.
  function automatic void modelOp(input logic signed [7:0] psum, input logic [2:0][1:0] w,
                                  input logic [2:0][1:0] x, output logic signed [7:0] out,
                                  output logic [1:0] zc);
    int acc;
    logic signed [7:0] folded;
    acc = psum;
    zc  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (x[i] == 2'b00) begin
        zc = zc + 2'd1;
      end else begin
        acc = acc + $signed(w[i]) * $signed(x[i]);
`ifdef CONV_PE_SAT_EN
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
`else
        folded = acc[7:0];
        acc = folded;
`endif
      end
    end
    out = acc[7:0];
  endfunction

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendPsum(input logic signed [7:0] v);
    int   budget;
    logic hs;
    in_valid = 1'b1;
    inpsum   = v;
    budget   = 20;
    do begin
      hs = in_ready;
      idleCycle();
      budget--;
    end while (!hs && budget > 0);
    in_valid = 1'b0;
    if (!hs) checkOutput("in_handshake_timeout", 0, 1);
  endtask

  task automatic sendTap(input logic [1:0] w, input logic [1:0] x);
    int   budget;
    logic hs;
    tap_valid    = 1'b1;
    weight       = w;
    infmap_value = x;
    budget       = 20;
    do begin
      hs = tap_ready;
      idleCycle();
      budget--;
    end while (!hs && budget > 0);
    tap_valid = 1'b0;
    if (!hs) checkOutput("tap_handshake_timeout", 0, 1);
  endtask

  task automatic waitOutDone();
    int budget;
    budget = 20;
    while (out_valid && budget > 0) begin
      idleCycle();
      budget--;
    end
    if (out_valid) checkOutput("out_drain_timeout", 0, 1);
  endtask

  // One full operation: result expected on the scoreboard, then psum and taps with optional gaps.
  task automatic applyStimulus(input logic signed [7:0] psum, input logic [2:0][1:0] w,
                               input logic [2:0][1:0] x, input int gap,
                               input logic signed [7:0] exp_out, input logic [1:0] exp_zero);
    exp_t e;
    e.out = exp_out;
    e.zc  = exp_zero;
    sb.push_back(e);
    sendPsum(psum);
    checkOutput("outpsum_hold_accum", int'(outpsum), int'(last_out));
    for (int i = 0; i < 3; i++) begin
      sendTap(w[i], x[i]);
      if (i < 2) repeat (gap) idleCycle();
    end
    checkOutput("out_valid_after_last_tap", int'(out_valid), 1);
    waitOutDone();
    last_out = exp_out;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("outpsum", int'(outpsum), int'(mon_exp.out));
        checkOutput("zero_count", int'(zero_count), int'(mon_exp.zc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [7:0] rp;
    logic [2:0][1:0]   rw, rx;
    logic signed [7:0] mo;
    logic [1:0]        mz;

    vecs[0] = mkVec(5,   1, -1,  1,  1, 1, -2,  3, 0, 0);
    vecs[1] = mkVec(-7,  1, -2,  1,  0, 0,  0, -7, 3, 0);
`ifdef CONV_PE_SAT_EN
    vecs[2] = mkVec(126, 1,  1, -2,  1, 1, -2, 127, 0, 0);
`else
    vecs[2] = mkVec(126, 1,  1, -2,  1, 1, -2, -124, 0, 0);
`endif
    vecs[3] = mkVec(5,   1, -1,  1,  1, 1, -2,  3, 0, 2);

    reset        = 1'b1;
    in_valid     = 1'b0;
    inpsum       = '0;
    tap_valid    = 1'b0;
    weight       = '0;
    infmap_value = '0;
    out_ready    = 1'b1;
    repeat (2) idleCycle();
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_tap_ready", int'(tap_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_outpsum", int'(outpsum), 0);
    checkOutput("reset_zero_count", int'(zero_count), 0);
    reset = 1'b0;
    idleCycle();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].psum, vecs[i].w, vecs[i].x, int'(vecs[i].gap),
                    vecs[i].exp_out, vecs[i].exp_zero);
    end

    for (int i = 0; i < 6; i++) begin
      rp = 8'($urandom);
      rw = 6'($urandom);
      rx = 6'($urandom);
      modelOp(rp, rw, rx, mo, mz);
      applyStimulus(rp, rw, rx, int'($urandom_range(0, 1)), mo, mz);
    end

    // Back-pressure in DONE while the other handshakes are poked.
    begin
      exp_t e;
      e.out = -8'sd7;
      e.zc  = 2'd3;
      sb.push_back(e);
    end
    sendPsum(-8'sd7);
    out_ready = 1'b0;
    sendTap(2'b01, 2'b00);
    sendTap(2'b10, 2'b00);
    sendTap(2'b01, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tap_valid    = (k % 2 == 0);
      in_valid     = (k % 2 == 1);
      inpsum       = 8'sd99;
      weight       = 2'b01;
      infmap_value = 2'b01;
      checkOutput("stall_out_valid", int'(out_valid), 1);
      checkOutput("stall_outpsum", int'(outpsum), -7);
      checkOutput("stall_in_ready", int'(in_ready), 0);
      idleCycle();
    end
    tap_valid = 1'b0;
    in_valid  = 1'b0;
    checkOutput("stall_zero_count", int'(zero_count), 3);
    out_ready = 1'b1;
    idleCycle();
    checkOutput("release_in_ready", int'(in_ready), 1);
    checkOutput("release_out_valid", int'(out_valid), 0);
    checkOutput("idle_outpsum_hold", int'(outpsum), -7);
    last_out = -8'sd7;

    // Reset in the middle of accumulation, after two taps.
    sendPsum(8'sd5);
    sendTap(2'b01, 2'b01);
    sendTap(2'b11, 2'b01);
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_outpsum", int'(outpsum), 0);
    checkOutput("midreset_zero_count", int'(zero_count), 0);
    checkOutput("midreset_in_ready", int'(in_ready), 1);
    checkOutput("midreset_tap_ready", int'(tap_ready), 0);
    idleCycle();
    reset    = 1'b0;
    last_out = '0;
    idleCycle();
    applyStimulus(vecs[0].psum, vecs[0].w, vecs[0].x, 0, 8'sd3, 2'd0);

    repeat (3) idleCycle();
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
